// File: rtl/score_ram_arbiter_if.sv
// Request/acknowledge bundle for one requester of the score RAM.
// Master: req/we/addr/wdata out, ack/rdata in. Slave: the arbiter side.
interface score_ram_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 7
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/score_ram_arbiter.sv
// Score RAM owner: arbitrates ports a/b onto one single-port RAM, zero-fills it.
// Ports: clk, rst (async low), clear_req, busy, a/b (slave bundles), RAM_* bus.
module score_ram_arbiter #(
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 7,
    parameter int RD_LAT        = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_req,
    output logic               busy,
    score_ram_arbiter_if.slave a,
    score_ram_arbiter_if.slave b,
    output logic [ADDR_W-1:0]  RAM_addr,
    output logic [DATA_W-1:0]  RAM_out,
    output logic               RAM_W,
    input  logic [DATA_W-1:0]  RAM_data
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic [1:0] S_RST =
        (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;

    localparam logic [ADDR_W:0] FILL_END = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]      LAT_END  = 2'(RD_LAT);

    logic [1:0]        state;
    logic [ADDR_W:0]   fill_cnt;
    logic [1:0]        lat_cnt;
    logic              last_b;
    logic              sel_b;
    logic              op_we;
    logic              clr_pend;

    logic              a_elig;
    logic              b_elig;
    logic              grant_b;
    logic              grant_any;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;

    // A port whose read ack is still showing has not yet had the
    // chance to drop req, so it is not eligible this cycle.
    always_comb begin
        a_elig    = a.req & ~a.ack;
        b_elig    = b.req & ~b.ack;
        grant_b   = b_elig & (~a_elig | ~last_b);
        grant_any = a_elig | b_elig;
        g_we      = grant_b ? b.we    : a.we;
        g_addr    = grant_b ? b.addr  : a.addr;
        g_wdata   = grant_b ? b.wdata : a.wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_RST;
            fill_cnt <= '0;
            lat_cnt  <= '0;
            last_b   <= 1'b1;
            sel_b    <= 1'b0;
            op_we    <= 1'b0;
            clr_pend <= 1'b0;
            busy     <= 1'b0;
            RAM_addr <= '0;
            RAM_out  <= '0;
            RAM_W    <= 1'b0;
            a.ack    <= 1'b0;
            a.rdata  <= '0;
            b.ack    <= 1'b0;
            b.rdata  <= '0;
        end else begin
            a.ack <= 1'b0;
            b.ack <= 1'b0;

            if (clear_req && state != S_IDLE)
                clr_pend <= 1'b1;

            unique case (state)
                S_INIT: begin
                    if (fill_cnt == FILL_END) begin
                        state    <= S_IDLE;
                        fill_cnt <= '0;
                        RAM_W    <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        RAM_addr <= fill_cnt[ADDR_W-1:0];
                        RAM_out  <= '0;
                        RAM_W    <= 1'b1;
                        busy     <= 1'b1;
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (clear_req || clr_pend) begin
                        state    <= S_INIT;
                        clr_pend <= 1'b0;
                    end else if (grant_any) begin
                        RAM_addr <= g_addr;
                        RAM_out  <= g_wdata;
                        RAM_W    <= g_we;
                        last_b   <= grant_b;
                        sel_b    <= grant_b;
                        op_we    <= g_we;
                        state    <= S_ISSUE;
                        // Writes complete on the grant edge itself.
                        if (g_we) begin
                            if (grant_b)
                                b.ack <= 1'b1;
                            else
                                a.ack <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    RAM_W <= 1'b0;
                    if (op_we) begin
                        state <= S_IDLE;
                    end else begin
                        state   <= S_WAIT;
                        lat_cnt <= 2'd1;
                    end
                end

                S_WAIT: begin
                    if (lat_cnt == LAT_END) begin
                        state <= S_IDLE;
                        if (sel_b) begin
                            b.rdata <= RAM_data;
                            b.ack   <= 1'b1;
                        end else begin
                            a.rdata <= RAM_data;
                            a.ack   <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
